// File: rtl/parallax_scroller_pkg.sv
// parallax_scroller_pkg: shared widths and FSM state encoding for the parallax scroller
package parallax_scroller_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int POS_W = 10;
  localparam int FRAC_BITS_DEF = 4;
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;
endpackage

// File: rtl/parallax_scroller_wrap_add.sv
// parallax_scroller_wrap_add: a + b with one conditional subtract of the wrap period.
// Ports:
//   a_i, b_i  addends (a_i < wrap_i and b_i < wrap_i keeps the result in range)
//   wrap_i    wrap period
//   sum_o     (a_i + b_i) reduced by wrap_i once if it reached wrap_i
module parallax_scroller_wrap_add #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] wrap_i,
  output logic [W-1:0] sum_o
);
  logic [W:0] s;
  assign s = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = W'((s >= {1'b0, wrap_i}) ? s - {1'b0, wrap_i} : s);
endmodule

// File: rtl/parallax_scroller.sv
// parallax_scroller: multi-layer fixed-point horizontal scroller with speed ramp and per-pixel layer/texture lookup.
// Ports:
//   clk, rst_n      pixel clock, synchronous active-low reset
//   fresh_i         frame strobe; its falling edge starts a layer update sweep
//   game_status_i   1 = running, 0 = stopped
//   x_i, y_i        current pixel column / row
//   layer_pos_o     integer scroll offset per layer, layer k at [10k+9:10k]
//   speed_o         current ground speed, fixed point
//   is_ground_o     pixel row is in the ground band (2-cycle latency)
//   layer_id_o      owning layer of the pixel, NUM_LAYERS = none (2-cycle latency)
//   tex_u_o         wrapped texture column of the owning layer (2-cycle latency)
//   busy_o          layer update sweep in progress
//   overrun_o       sticky: a frame edge arrived during a sweep
module parallax_scroller
  import parallax_scroller_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int BASE_SPEED = 3,
  parameter int MAX_SPEED = 7,
  parameter int RAMP_FRAMES = 256,
  parameter int RAMP_STEP = 1,
  parameter logic [NUM_LAYERS*POS_W-1:0] LAYER_WRAP = {10'd288, 10'd320, 10'd336},
  parameter logic [NUM_LAYERS*Y_W-1:0] LAYER_YTOP = {9'd0, 9'd300, 9'd425},
  localparam int LID_W = $clog2(NUM_LAYERS + 1),
  localparam int SPD_W = 4 + FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fresh_i,
  input  logic                        game_status_i,
  input  logic [X_W-1:0]              x_i,
  input  logic [Y_W-1:0]              y_i,
  output logic [NUM_LAYERS*POS_W-1:0] layer_pos_o,
  output logic [SPD_W-1:0]            speed_o,
  output logic                        is_ground_o,
  output logic [LID_W-1:0]            layer_id_o,
  output logic [POS_W-1:0]            tex_u_o,
  output logic                        busy_o,
  output logic                        overrun_o
);
  localparam int ACC_W = POS_W + FRAC_BITS;
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [SPD_W-1:0] BASE_Q = SPD_W'(BASE_SPEED << FRAC_BITS);
  localparam logic [SPD_W-1:0] MAX_Q = SPD_W'(MAX_SPEED << FRAC_BITS);
  localparam logic [LID_W-1:0] NONE = LID_W'(NUM_LAYERS);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SPD_W-1:0]   speed_q, sweep_spd_q, speed_step_d;
  logic [SPD_W:0]     speed_sum;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q [NUM_LAYERS];
  logic [POS_W-1:0]   pos_q [NUM_LAYERS];
  logic               fresh_q, busy_q, overrun_q, tick;
  logic [ACC_W-1:0]   acc_sel, acc_inc, acc_wrap, acc_d;
  logic [X_W-1:0]     x_q;
  logic [LID_W-1:0]   owner_d, owner_q, layer_id_q;
  logic               gnd1_q, gnd2_q;
  logic [POS_W-1:0]   pos_t, wrap_t, tex_q, tex2, tex_d;
  logic [POS_W:0]     tex1;

  assign tick = fresh_q & ~fresh_i;
  assign speed_sum = {1'b0, speed_q} + (SPD_W+1)'(RAMP_STEP);
  assign speed_step_d = (speed_sum > {1'b0, MAX_Q}) ? MAX_Q : speed_sum[SPD_W-1:0];
  // layer k advances at speed >> k, using the speed latched when the sweep began
  assign acc_inc = ACC_W'(sweep_spd_q >> idx_q);

  always_comb begin
    acc_sel = '0;
    acc_wrap = '0;
    pos_t = '0;
    wrap_t = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        acc_sel = acc_q[k];
        acc_wrap = ACC_W'(LAYER_WRAP[POS_W*k +: POS_W]) << FRAC_BITS;
      end
      if (owner_q == LID_W'(k)) begin
        pos_t = pos_q[k];
        wrap_t = LAYER_WRAP[POS_W*k +: POS_W];
      end
    end
  end

  // descending scan so the lowest matching layer wins
  always_comb begin
    owner_d = NONE;
    for (int k = NUM_LAYERS - 1; k >= 0; k--)
      if (y_i >= LAYER_YTOP[Y_W*k +: Y_W]) owner_d = LID_W'(k);
  end

  parallax_scroller_wrap_add #(.W(ACC_W)) u_sweep_add (
    .a_i   (acc_sel),
    .b_i   (acc_inc),
    .wrap_i(acc_wrap),
    .sum_o (acc_d)
  );

  parallax_scroller_wrap_add #(.W(POS_W + 1)) u_tex_add (
    .a_i   ((POS_W+1)'(x_q)),
    .b_i   ({1'b0, pos_t}),
    .wrap_i({1'b0, wrap_t}),
    .sum_o (tex1)
  );

  // x can exceed one wrap period, so a second subtract may still be needed
  assign tex2 = POS_W'((tex1 >= {1'b0, wrap_t}) ? tex1 - {1'b0, wrap_t} : tex1);
  assign tex_d = (owner_q == NONE) ? '0 : tex2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      idx_q <= '0;
      speed_q <= BASE_Q;
      sweep_spd_q <= BASE_Q;
      cnt_q <= '0;
      fresh_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        acc_q[k] <= '0;
        pos_q[k] <= '0;
      end
      x_q <= '0;
      owner_q <= NONE;
      gnd1_q <= 1'b0;
      layer_id_q <= NONE;
      tex_q <= '0;
      gnd2_q <= 1'b0;
    end else begin
      fresh_q <= fresh_i;
      x_q <= x_i;
      owner_q <= owner_d;
      gnd1_q <= (y_i >= LAYER_YTOP[Y_W-1:0]);
      layer_id_q <= owner_q;
      tex_q <= tex_d;
      gnd2_q <= gnd1_q;
      case (state_q)
        ST_STOP: begin
          speed_q <= BASE_Q;
          cnt_q <= '0;
          if (tick && game_status_i) begin
            state_q <= ST_SWEEP;
            busy_q <= 1'b1;
            idx_q <= '0;
            sweep_spd_q <= BASE_Q;
          end
        end
        ST_RUN: begin
          if (tick) begin
            state_q <= ST_SWEEP;
            busy_q <= 1'b1;
            idx_q <= '0;
            sweep_spd_q <= speed_q;
            cnt_q <= (cnt_q == CNT_W'(RAMP_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_W'(RAMP_FRAMES - 1)) speed_q <= speed_step_d;
          end
        end
        ST_SWEEP: begin
          if (tick) overrun_q <= 1'b1;
          acc_q[idx_q] <= acc_d;
          pos_q[idx_q] <= POS_W'(acc_d >> FRAC_BITS);
          if (idx_q == IDX_W'(NUM_LAYERS - 1)) begin
            state_q <= game_status_i ? ST_RUN : ST_STOP;
            busy_q <= 1'b0;
            if (!game_status_i) begin
              speed_q <= BASE_Q;
              cnt_q <= '0;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_STOP;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_pos
    assign layer_pos_o[POS_W*i +: POS_W] = pos_q[i];
  end

  assign speed_o = speed_q;
  assign busy_o = busy_q;
  assign overrun_o = overrun_q;
  assign is_ground_o = gnd2_q;
  assign layer_id_o = layer_id_q;
  assign tex_u_o = tex_q;
endmodule
